// File: rtl/acoustics_pkg.sv
// Shared definitions for the hydrophone acquisition blocks: default widths, the
// sequencer state encoding and the channel-index width helper.
package acoustics_pkg;

    localparam int unsigned DEF_NUM_CH = 4;
    localparam int unsigned DEF_DATA_W = 10;

    typedef enum logic [2:0] {
        StIdle,
        StReq,
        StWait,
        StUpdate,
        StReport
    } state_e;

    // Index width for n items; never narrower than one bit.
    function automatic int unsigned ch_width(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/peak_window_sequencer_if.sv
// Control, SPI-request and window-result signals of peak_window_sequencer.
// master drives the commands, SPI responses and result_ready; slave is the sequencer.
interface peak_window_sequencer_if
    import acoustics_pkg::*;
#(
    parameter int unsigned NUM_CH = DEF_NUM_CH,
    parameter int unsigned DATA_W = DEF_DATA_W
);
    localparam int unsigned CH_W = ch_width(NUM_CH);

    logic                     start;
    logic                     continuous;
    logic                     abort;
    logic                     spi_start;
    logic [CH_W-1:0]          adc_ch;
    logic                     spi_done;
    logic [DATA_W-1:0]        spi_data;
    logic                     busy;
    logic                     result_valid;
    logic                     result_ready;
    logic [NUM_CH*DATA_W-1:0] peaks;
    logic [CH_W-1:0]          max_ch;
    logic                     trigger;
    logic                     timeout_err;

    modport master (
        output start, continuous, abort, spi_done, spi_data, result_ready,
        input  spi_start, adc_ch, busy, result_valid, peaks, max_ch, trigger, timeout_err
    );

    modport slave (
        input  start, continuous, abort, spi_done, spi_data, result_ready,
        output spi_start, adc_ch, busy, result_valid, peaks, max_ch, trigger, timeout_err
    );

endinterface

// File: rtl/peak_hold.sv
// Single-channel peak-hold register: keeps the largest sample seen since the last clear.
module peak_hold
    import acoustics_pkg::*;
#(
    parameter int unsigned DATA_W = DEF_DATA_W
) (
    input  logic              clk,
    input  logic              reset_b,
    input  logic              clear_i,
    input  logic              en_i,
    input  logic [DATA_W-1:0] din_i,
    output logic [DATA_W-1:0] peak_o
);

    logic [DATA_W-1:0] peak_q;

    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            peak_q <= '0;
        end else if (clear_i) begin
            peak_q <= '0;
        end else if (en_i && (din_i > peak_q)) begin
            peak_q <= din_i;
        end
    end

    assign peak_o = peak_q;

endmodule

// File: rtl/peak_window_sequencer.sv
// Round-robins SPI ADC conversions over all channels for a fixed window, tracks
// per-channel peaks and reports peaks, loudest channel and trigger over valid/ready.
module peak_window_sequencer
    import acoustics_pkg::*;
#(
    parameter int unsigned       NUM_CH      = DEF_NUM_CH,
    parameter int unsigned       DATA_W      = DEF_DATA_W,
    parameter int unsigned       WINDOW_LEN  = 1024,
    parameter int unsigned       TIMEOUT_CYC = 64,
    parameter logic [DATA_W-1:0] THRESHOLD   = DATA_W'(512)
) (
    input logic                    clk,
    input logic                    reset_b,
    peak_window_sequencer_if.slave bus_io
);

    localparam int unsigned CH_W  = ch_width(NUM_CH);
    localparam int unsigned CNT_W = ch_width(WINDOW_LEN);
    localparam int unsigned TMO_W = ch_width(TIMEOUT_CYC);

    state_e            state_q, state_d;
    logic [CH_W-1:0]   ch_q, ch_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [TMO_W-1:0]  tmo_q, tmo_d;
    logic [DATA_W-1:0] sample_q, sample_d;
    logic [CH_W-1:0]   max_ch_q, max_ch_d;
    logic              trigger_q, trigger_d;
    logic              timeout_err_q, timeout_err_d;
    logic              spi_start_q, busy_q, result_valid_q;
    logic              clear_peaks;

    logic [NUM_CH-1:0] en;
    logic [DATA_W-1:0] peak_cur [NUM_CH];
    logic [DATA_W-1:0] peak_nxt [NUM_CH];
    logic [DATA_W-1:0] best_val;
    logic [CH_W-1:0]   best_idx;
    logic              trig_c;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        assign en[g] = (state_q == StUpdate) && (ch_q == CH_W'(g));

        peak_hold #(
            .DATA_W (DATA_W)
        ) u_peak (
            .clk     (clk),
            .reset_b (reset_b),
            .clear_i (clear_peaks),
            .en_i    (en[g]),
            .din_i   (sample_q),
            .peak_o  (peak_cur[g])
        );

        assign bus_io.peaks[g*DATA_W +: DATA_W] = peak_cur[g];
    end

    // Reduction looks at the post-update peaks so it can be latched on the same
    // edge that ends the final UPDATE and enters REPORT.
    always_comb begin
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            peak_nxt[i] = (en[i] && (sample_q > peak_cur[i])) ? sample_q : peak_cur[i];
        end
    end

    always_comb begin
        best_val = peak_nxt[0];
        best_idx = '0;
        trig_c   = (peak_nxt[0] >= THRESHOLD);
        for (int unsigned i = 1; i < NUM_CH; i++) begin
            if (peak_nxt[i] > best_val) begin
                best_val = peak_nxt[i];
                best_idx = CH_W'(i);
            end
            if (peak_nxt[i] >= THRESHOLD) begin
                trig_c = 1'b1;
            end
        end
    end

    always_comb begin
        state_d       = state_q;
        ch_d          = ch_q;
        cnt_d         = cnt_q;
        tmo_d         = tmo_q;
        sample_d      = sample_q;
        max_ch_d      = max_ch_q;
        trigger_d     = trigger_q;
        timeout_err_d = timeout_err_q;
        clear_peaks   = 1'b0;

        if (bus_io.abort) begin
            state_d = StIdle;
        end else begin
            case (state_q)
                StIdle: begin
                    if (bus_io.start) begin
                        clear_peaks   = 1'b1;
                        timeout_err_d = 1'b0;
                        ch_d          = '0;
                        cnt_d         = '0;
                        state_d       = StReq;
                    end
                end
                StReq: begin
                    tmo_d   = '0;
                    state_d = StWait;
                end
                StWait: begin
                    if (bus_io.spi_done) begin
                        sample_d = bus_io.spi_data;
                        state_d  = StUpdate;
                    end else if (tmo_q == TMO_W'(TIMEOUT_CYC - 1)) begin
                        timeout_err_d = 1'b1;
                        sample_d      = '0;
                        state_d       = StUpdate;
                    end else begin
                        tmo_d = tmo_q + TMO_W'(1);
                    end
                end
                StUpdate: begin
                    if (ch_q != CH_W'(NUM_CH - 1)) begin
                        ch_d    = ch_q + CH_W'(1);
                        state_d = StReq;
                    end else begin
                        ch_d = '0;
                        if (cnt_q == CNT_W'(WINDOW_LEN - 1)) begin
                            max_ch_d  = best_idx;
                            trigger_d = trig_c;
                            state_d   = StReport;
                        end else begin
                            cnt_d   = cnt_q + CNT_W'(1);
                            state_d = StReq;
                        end
                    end
                end
                StReport: begin
                    if (bus_io.result_ready) begin
                        if (bus_io.continuous) begin
                            clear_peaks = 1'b1;
                            cnt_d       = '0;
                            state_d     = StReq;
                        end else begin
                            state_d = StIdle;
                        end
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            state_q        <= StIdle;
            ch_q           <= '0;
            cnt_q          <= '0;
            tmo_q          <= '0;
            sample_q       <= '0;
            max_ch_q       <= '0;
            trigger_q      <= 1'b0;
            timeout_err_q  <= 1'b0;
            spi_start_q    <= 1'b0;
            busy_q         <= 1'b0;
            result_valid_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            ch_q           <= ch_d;
            cnt_q          <= cnt_d;
            tmo_q          <= tmo_d;
            sample_q       <= sample_d;
            max_ch_q       <= max_ch_d;
            trigger_q      <= trigger_d;
            timeout_err_q  <= timeout_err_d;
            spi_start_q    <= (state_d == StReq);
            busy_q         <= (state_d != StIdle);
            result_valid_q <= (state_d == StReport);
        end
    end

    assign bus_io.spi_start    = spi_start_q;
    assign bus_io.adc_ch       = ch_q;
    assign bus_io.busy         = busy_q;
    assign bus_io.result_valid = result_valid_q;
    assign bus_io.max_ch       = max_ch_q;
    assign bus_io.trigger      = trigger_q;
    assign bus_io.timeout_err  = timeout_err_q;

endmodule

// File: tb/tb_peak_window_sequencer.sv
// Bench for peak_window_sequencer: SPI responder model, table of window vectors with a
// scoreboard queue, and hand-written latency, continuous, abort and reset sequences.
module tb_peak_window_sequencer;

    localparam int unsigned NUM_CH      = 4;
    localparam int unsigned DATA_W      = 10;
    localparam int unsigned WINDOW_LEN  = 2;
    localparam int unsigned TIMEOUT_CYC = 64;
    localparam int unsigned PW          = NUM_CH * DATA_W;

    logic clk = 1'b0;
    logic reset_b;
    always #5 clk = ~clk;

    peak_window_sequencer_if #(.NUM_CH(NUM_CH), .DATA_W(DATA_W)) bus ();

    peak_window_sequencer #(
        .NUM_CH      (NUM_CH),
        .DATA_W      (DATA_W),
        .WINDOW_LEN  (WINDOW_LEN),
        .TIMEOUT_CYC (TIMEOUT_CYC),
        .THRESHOLD   (10'd512)
    ) dut (
        .clk     (clk),
        .reset_b (reset_b),
        .bus_io  (bus)
    );

    typedef struct {
        int          mode;
        logic [PW-1:0] peaks;
        int          max_ch;
        bit          trig;
        bit          terr;
    } exp_t;

    int   n_chk  = 0;
    int   n_fail = 0;
    int   mode   = 0;
    exp_t vecs [4];
    exp_t sb_q [$];

    // Responder: modes 0/3 return ch*100+n, mode 1 a single full-scale hit on channel 2,
    // mode 2 ties on channels 1 and 3, mode 3 never answers channel 1, mode 4 holds
    // spi_done high for minimum-latency conversions.
    int unsigned       req_cnt [NUM_CH];
    int                pend;
    logic [DATA_W-1:0] pdata;
    int                gap_cnt;
    int                prev_ch;
    int                t1_gap;
    int                rc;

    function automatic logic [DATA_W-1:0] model_data(input int m, input int ch, input int n);
        case (m)
            1:       return (ch == 2 && n == 0) ? 10'h3FF : 10'd5;
            2:       return (ch == 1 || ch == 3) ? 10'd700 : 10'd10;
            4:       return 10'd7;
            default: return DATA_W'(ch * 100 + n);
        endcase
    endfunction

    initial begin
        bus.spi_done = 1'b0;
        bus.spi_data = '0;
        pend    = 0;
        gap_cnt = 0;
        prev_ch = -1;
        t1_gap  = 0;
        for (int c = 0; c < NUM_CH; c++) req_cnt[c] = 0;
        forever begin
            @(negedge clk);
            bus.spi_done = 1'b0;
            if (!bus.busy || bus.result_valid) begin
                for (int c = 0; c < NUM_CH; c++) req_cnt[c] = 0;
            end
            if (pend > 0) begin
                pend--;
                if (pend == 0) begin
                    bus.spi_done = 1'b1;
                    bus.spi_data = pdata;
                end
            end
            gap_cnt++;
            if (bus.spi_start) begin
                rc = int'(bus.adc_ch);
                if (prev_ch == 1 && mode == 3) t1_gap = gap_cnt;
                gap_cnt = 0;
                prev_ch = rc;
                if (!(mode == 3 && rc == 1)) begin
                    pdata = model_data(mode, rc, int'(req_cnt[rc]));
                    pend  = 2;
                end
                req_cnt[rc]++;
            end
            if (mode == 4) begin
                bus.spi_done = 1'b1;
                bus.spi_data = 10'd7;
            end
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic start_pulse();
        @(negedge clk);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic ready_pulse();
        @(negedge clk);
        bus.result_ready = 1'b1;
        @(negedge clk);
        bus.result_ready = 1'b0;
    endtask

    task automatic wait_valid(input int budget, output int waited);
        waited = 0;
        while (!bus.result_valid && waited < budget) begin
            @(negedge clk);
            waited++;
        end
        chk("valid_arrives", 64'(bus.result_valid), 64'd1);
    endtask

    task automatic check_result(input string tag);
        exp_t e;
        if (sb_q.size() == 0) begin
            chk({tag, "_sb_empty"}, 64'd0, 64'd1);
        end else begin
            e = sb_q.pop_front();
            chk({tag, "_peaks"}, 64'(bus.peaks), 64'(e.peaks));
            chk({tag, "_max_ch"}, 64'(bus.max_ch), 64'(e.max_ch));
            chk({tag, "_trigger"}, 64'(bus.trigger), 64'(e.trig));
            chk({tag, "_timeout_err"}, 64'(bus.timeout_err), 64'(e.terr));
        end
    endtask

    initial begin
        int w;
        int k;
        bit seen;
        exp_t fast;

        reset_b          = 1'b0;
        bus.start        = 1'b0;
        bus.continuous   = 1'b0;
        bus.abort        = 1'b0;
        bus.result_ready = 1'b0;

        vecs[0] = '{0, {10'd301, 10'd201, 10'd101, 10'd1}, 3, 1'b0, 1'b0};
        vecs[1] = '{3, {10'd301, 10'd201, 10'd0, 10'd1}, 3, 1'b0, 1'b1};
        vecs[2] = '{1, {10'd5, 10'd1023, 10'd5, 10'd5}, 2, 1'b1, 1'b0};
        vecs[3] = '{2, {10'd700, 10'd10, 10'd700, 10'd10}, 1, 1'b1, 1'b0};

        repeat (3) @(negedge clk);
        chk("rst_spi_start", 64'(bus.spi_start), 64'd0);
        chk("rst_busy", 64'(bus.busy), 64'd0);
        chk("rst_valid", 64'(bus.result_valid), 64'd0);
        chk("rst_peaks", 64'(bus.peaks), 64'd0);
        chk("rst_max_ch", 64'(bus.max_ch), 64'd0);
        chk("rst_trigger", 64'(bus.trigger), 64'd0);
        reset_b = 1'b1;

        for (int i = 0; i < 4; i++) begin
            mode = vecs[i].mode;
            sb_q.push_back(vecs[i]);
            start_pulse();
            wait_valid(2000, w);
            check_result($sformatf("vec%0d", i));
            repeat (3) @(negedge clk);
            chk($sformatf("vec%0d_hold_valid", i), 64'(bus.result_valid), 64'd1);
            chk($sformatf("vec%0d_hold_peaks", i), 64'(bus.peaks), 64'(vecs[i].peaks));
            ready_pulse();
            chk($sformatf("vec%0d_idle_busy", i), 64'(bus.busy), 64'd0);
            chk($sformatf("vec%0d_idle_valid", i), 64'(bus.result_valid), 64'd0);
            chk($sformatf("vec%0d_keep_peaks", i), 64'(bus.peaks), 64'(vecs[i].peaks));
        end
        // REQ + 64 WAIT + UPDATE between the silent channel-1 request and the next one.
        chk("timeout_gap", 64'(t1_gap), 64'(TIMEOUT_CYC + 2));

        // Reset mid-window with timeout_err, trigger and max_ch all non-zero.
        mode = 3;
        start_pulse();
        k = 0;
        while (!bus.timeout_err && k < 500) begin
            @(negedge clk);
            k++;
        end
        chk("mid_timeout_err", 64'(bus.timeout_err), 64'd1);
        reset_b = 1'b0;
        #1;
        chk("mid_rst_busy", 64'(bus.busy), 64'd0);
        chk("mid_rst_spi_start", 64'(bus.spi_start), 64'd0);
        chk("mid_rst_timeout_err", 64'(bus.timeout_err), 64'd0);
        chk("mid_rst_trigger", 64'(bus.trigger), 64'd0);
        chk("mid_rst_max_ch", 64'(bus.max_ch), 64'd0);
        chk("mid_rst_adc_ch", 64'(bus.adc_ch), 64'd0);
        chk("mid_rst_peaks", 64'(bus.peaks), 64'd0);
        @(negedge clk);
        reset_b = 1'b1;
        seen = 1'b0;
        repeat (10) begin
            @(negedge clk);
            if (bus.busy || bus.result_valid) seen = 1'b1;
        end
        chk("mid_rst_stays_idle", 64'(seen), 64'd0);

        // Minimum-latency window; constant data also exercises the lowest-index tie rule.
        mode = 4;
        fast = '{4, {10'd7, 10'd7, 10'd7, 10'd7}, 0, 1'b0, 1'b0};
        sb_q.push_back(fast);
        start_pulse();
        wait_valid(200, w);
        chk("fast_latency", 64'(w + 1), 64'(3 * NUM_CH * WINDOW_LEN + 1));
        check_result("fast");
        ready_pulse();
        mode = 0;

        // Continuous mode: two back-to-back windows.
        bus.continuous = 1'b1;
        sb_q.push_back(vecs[0]);
        sb_q.push_back(vecs[0]);
        start_pulse();
        wait_valid(2000, w);
        check_result("cont1");
        @(negedge clk);
        bus.result_ready = 1'b1;
        @(negedge clk);
        bus.result_ready = 1'b0;
        bus.continuous   = 1'b0;
        chk("cont_spi_start", 64'(bus.spi_start), 64'd1);
        chk("cont_valid_low", 64'(bus.result_valid), 64'd0);
        chk("cont_peaks_clr", 64'(bus.peaks), 64'd0);
        wait_valid(2000, w);
        check_result("cont2");
        ready_pulse();
        chk("cont_end_busy", 64'(bus.busy), 64'd0);

        // Abort in WAIT of the first channel-2 conversion.
        start_pulse();
        k = 0;
        while (!(bus.spi_start && bus.adc_ch == 2'd2) && k < 100) begin
            @(negedge clk);
            k++;
        end
        chk("abort_reach_ch2", 64'(bus.spi_start), 64'd1);
        @(negedge clk);
        bus.abort = 1'b1;
        @(negedge clk);
        bus.abort = 1'b0;
        chk("abort_busy", 64'(bus.busy), 64'd0);
        chk("abort_spi_start", 64'(bus.spi_start), 64'd0);
        chk("abort_valid", 64'(bus.result_valid), 64'd0);
        chk("abort_peaks", 64'(bus.peaks), 64'({10'd0, 10'd0, 10'd100, 10'd0}));
        seen = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (bus.busy || bus.result_valid) seen = 1'b1;
        end
        chk("abort_no_result", 64'(seen), 64'd0);

        // abort and start together in IDLE: abort wins.
        @(negedge clk);
        bus.start = 1'b1;
        bus.abort = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        bus.abort = 1'b0;
        chk("abort_start_idle", 64'(bus.busy), 64'd0);
        chk("sb_drained", 64'(sb_q.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
